led_scan_sequencer: RTL
=======================

# led_scan_sequencer

Scan controller for a HUB75-style 32-row RGB LED matrix with 1/16 scan. It sequences framebuffer reads, serial column shifting, latching, row addressing and binary-code-modulated (BCM) output-enable timing for each bit plane. It sits between the AVR-facing register/framebuffer logic of the LED driver XB and the panel pins.

## Interface
Parameters:
- COLS, 32, columns per panel row; power of 2, range 2..64
- BITS, 4, bit planes per colour; range 1..8

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- clken  in  1  clock enable; the FSM and counters advance only when clken=1
- enable  in  1  run scanning; 0 forces IDLE
- brightness  in  8  OE on-time scale
- fb_rd  out  1  framebuffer read strobe
- fb_addr  out  4+log2(COLS)  {row[3:0], col}
- fb_data  in  6*BITS  {r1,g1,b1,r2,g2,b2}, each BITS wide; valid one clken-cycle after fb_rd
- clk_out  out  1  panel shift clock
- r1, g1, b1, r2, g2, b2  out  1 each  panel serial data; upper half uses r1/g1/b1, lower half uses r2/g2/b2
- a, b, c, d  out  1 each  row address; a is the LSB
- latch_SR  out  1  panel latch
- oe  out  1  panel output enable, active low
- frame_done  out  1  one-cycle end-of-frame pulse

## Operation
- Reset values: oe=1. All other outputs are 0, including fb_addr, a-d and frame_done. FSM is in IDLE; row=0, plane=0, col=0.
- States and transitions:
  - IDLE → RD when enable=1.
  - RD: fb_rd=1, fb_addr={row,col}, clk_out=0 → SET.
  - SET: capture bit [plane] of each colour field of fb_data onto the r/g/b outputs; clk_out=0 → CLK.
  - CLK: clk_out=1. If col=COLS-1, go to BLANK and clear col; otherwise increment col and go to RD.
  - BLANK: oe=1, clk_out=0; {d,c,b,a} ← row → LATCH.
  - LATCH: latch_SR=1; load the display counter with (brightness+1)<<plane → DISP.
  - DISP: oe=0 while the counter decrements. At count 1, go to NEXT.
  - NEXT: oe=1. Advance plane; when plane wraps from BITS-1 to 0, advance row (modulo 16). When row wraps from 15 to 0, pulse frame_done=1 for this cycle. → RD.
- Ordering: row is the outer loop and plane is the inner loop. Both fields of a framebuffer word are shifted in the same column slot.
- Display counter is 12 bits; the maximum count is 256<<7 = 32768, so BITS=8 requires 16 bits. Size the counter as 8+BITS bits. brightness is sampled only in LATCH; changes mid-DISP do not affect the current count.
- oe is 0 only in DISP. Row address lines change only in BLANK, while oe=1.
- enable=0 in any state: on the next edge the FSM goes to IDLE, oe=1, clk_out=0, latch_SR=0 and fb_rd=0. row, plane and col are cleared. r/g/b and a-d hold their values.
- clken=0: all registers hold, so outputs are frozen, and no fb_rd is issued. fb_rd asserts for exactly one clken-qualified cycle per read.
- An asynchronous reset mid-operation returns every output to its reset value immediately.

## Timing
- enable rising while in IDLE: first fb_rd one cycle later.
- Per column: 3 cycles (RD, SET, CLK). r/g/b are stable for one full cycle before clk_out rises, and hold through the clk_out-high cycle.
- Per row-plane: 3*COLS + 1 (BLANK) + 1 (LATCH) + (brightness+1)<<plane (DISP) + 1 (NEXT) cycles. With COLS=32, brightness=0, plane=0 this is 100 cycles.
- latch_SR is high for exactly 1 cycle, 2 cycles after the last clk_out rise.
- A frame is 16*BITS row-planes. frame_done asserts in the final NEXT cycle.
- Cycle counts above assume clken=1. With gated clken, durations scale by the number of clken cycles.

## Test plan
- Reset: hold rstn=0 → oe=1, all other outputs 0. Release with enable=0 → state is unchanged for 20 cycles.
- Enable with brightness=0 and a framebuffer model returning col-dependent data → fb_addr sequence 0..31 with one read per 3 cycles. Verify 32 clk_out rises, 1 latch_SR cycle, then oe low for 1, 2, 4 and 8 cycles on planes 0-3.
- Data mapping: word at {row 2, col 5} has r1 field=4'b1010 and b2 field=4'b0101 → at the 6th clk_out rise of row 2, r1=1 on planes 1 and 3, and b2=1 on planes 0 and 2. {d,c,b,a}=4'b0010 during that row's DISP.
- brightness=3 → plane 2 has oe low for exactly 16 cycles. Changing brightness mid-DISP leaves the current count unchanged.
- Full frame: 64 row-planes → exactly one frame_done pulse, at the last NEXT. The address then returns to row 0, and the next fb_addr is 0.
- Abort and throttle: drop enable mid-DISP → oe=1 next cycle, then IDLE; re-enable restarts at fb_addr=0, plane 0. With clken toggling 1,0,1,0 → identical output sequence at twice the durations, and one fb_rd pulse per column.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// -----------------------------------------------------------------------------
// led_scan_sequencer
//
// Scan controller for a HUB75-style 32-row RGB matrix driven at 1/16 scan.
// For every (row, bit plane) pair it reads one framebuffer word per column and
// shifts the selected bit plane of both panel halves out serially. It then
// blanks, updates the row address, latches, and holds the output enable low for
// a binary-weighted time of (brightness+1) << plane.
//
// Loop order: row is the outer loop (0..15) and plane is the inner loop
// (0..BITS-1). One frame is 16*BITS row-planes.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   clken              clock enable; state and counters advance only when high
//   enable             run scanning; low aborts to IDLE and clears row/plane/col
//   brightness[7:0]    display-time scale, sampled in LATCH only
//   fb_rd, fb_addr     framebuffer read strobe and address {row[3:0], col}
//   fb_data            {r1,g1,b1,r2,g2,b2}, each BITS wide
//   clk_out            panel shift clock
//   r1..b2             panel serial data (r1/g1/b1 upper half, r2/g2/b2 lower)
//   a, b, c, d         row address, a is the LSB
//   latch_SR           panel latch
//   oe                 panel output enable, active low
//   frame_done         one-cycle pulse in the final NEXT of a frame
//   state_dbg          current FSM state encoding, for observation only
//
// Framebuffer read contract: fb_rd is a strobe with no back-pressure. It is
// high for exactly one clken-qualified cycle per column, with fb_addr stable
// in that cycle. The framebuffer returns fb_data in the following cycle (SET)
// and holds it until the next fb_rd.
// -----------------------------------------------------------------------------
module led_scan_sequencer #(
  parameter int COLS = 32,
  parameter int BITS = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clken,
  input  logic                     enable,
  input  logic [7:0]               brightness,
  output logic                     fb_rd,
  output logic [3+$clog2(COLS):0]  fb_addr,
  input  logic [6*BITS-1:0]        fb_data,
  output logic                     clk_out,
  output logic                     r1,
  output logic                     g1,
  output logic                     b1,
  output logic                     r2,
  output logic                     g2,
  output logic                     b2,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     d,
  output logic                     latch_SR,
  output logic                     oe,
  output logic                     frame_done,
  output logic [2:0]               state_dbg
);

  localparam int CW = $clog2(COLS);
  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
  // The display count reaches 256 << (BITS-1), which needs 8+BITS bits.
  localparam int DW = 8 + BITS;

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_SET   = 3'd2,
    S_CLK   = 3'd3,
    S_BLANK = 3'd4,
    S_LATCH = 3'd5,
    S_DISP  = 3'd6,
    S_NEXT  = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [CW-1:0]   col;
  logic [3:0]      row;
  logic [PW-1:0]   plane;
  logic [DW-1:0]   disp_cnt;
  logic [DW-1:0]   disp_load;
  logic [3:0]      row_addr;
  logic [5:0]      pix_live;
  logic [5:0]      pix_q;
  logic            last_rp;

  logic [BITS-1:0] f_r1;
  logic [BITS-1:0] f_g1;
  logic [BITS-1:0] f_b1;
  logic [BITS-1:0] f_r2;
  logic [BITS-1:0] f_g2;
  logic [BITS-1:0] f_b2;

  assign f_r1 = fb_data[5*BITS +: BITS];
  assign f_g1 = fb_data[4*BITS +: BITS];
  assign f_b1 = fb_data[3*BITS +: BITS];
  assign f_r2 = fb_data[2*BITS +: BITS];
  assign f_g2 = fb_data[1*BITS +: BITS];
  assign f_b2 = fb_data[0 +: BITS];

  // Bit [plane] of every colour field of the word returned for this column.
  assign pix_live = {f_r1[plane], f_g1[plane], f_b1[plane],
                     f_r2[plane], f_g2[plane], f_b2[plane]};

  assign disp_load = (DW'(brightness) + DW'(1)) << plane;
  assign last_rp   = (row == 4'hF) && (plane == PLANE_LAST);

  // ---------------------------------------------------------------------------
  // State register. Dropping enable aborts from any state on the next edge,
  // independent of clken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else if (!enable) begin
      state <= S_IDLE;
    end else if (clken) begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = enable ? S_RD : S_IDLE;
      S_RD:    state_nxt = S_SET;
      S_SET:   state_nxt = S_CLK;
      S_CLK:   state_nxt = (col == COL_LAST) ? S_BLANK : S_RD;
      S_BLANK: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_DISP;
      S_DISP:  state_nxt = (disp_cnt == DW'(1)) ? S_NEXT : S_DISP;
      S_NEXT:  state_nxt = S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan counters and display counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col      <= '0;
      row      <= '0;
      plane    <= '0;
      disp_cnt <= '0;
    end else if (!enable) begin
      col      <= '0;
      row      <= '0;
      plane    <= '0;
      disp_cnt <= '0;
    end else if (clken) begin
      unique case (state)
        S_CLK:   col <= (col == COL_LAST) ? '0 : col + CW'(1);
        S_LATCH: disp_cnt <= disp_load;
        S_DISP:  disp_cnt <= disp_cnt - DW'(1);
        S_NEXT: begin
          if (plane == PLANE_LAST) begin
            plane <= '0;
            row   <= row + 4'd1;
          end else begin
            plane <= plane + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel and row-address holding registers. r/g/b are driven straight from the
  // returned word during SET so they settle a full cycle before clk_out rises.
  // The register keeps that value through CLK and beyond, including after an
  // abort. The row address only moves in BLANK, when oe is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_q    <= '0;
      row_addr <= '0;
    end else begin
      if (state == S_SET) begin
        pix_q <= pix_live;
      end
      if ((state == S_BLANK) && enable && clken) begin
        row_addr <= row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    fb_rd      = 1'b0;
    clk_out    = 1'b0;
    latch_SR   = 1'b0;
    oe         = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_RD:    fb_rd      = clken && enable;
      S_CLK:   clk_out    = 1'b1;
      S_LATCH: latch_SR   = 1'b1;
      S_DISP:  oe         = 1'b0;
      S_NEXT:  frame_done = clken && enable && last_rp;
      default: ;
    endcase
  end

  assign {r1, g1, b1, r2, g2, b2} = (state == S_SET) ? pix_live : pix_q;
  assign {d, c, b, a}             = row_addr;
  assign fb_addr                  = {row, col};
  assign state_dbg                = state;

endmodule
